tile_fetch_memory: RTL and testbench

Parametrised, word-addressed scratchpad for the TTPU. It has a single-word write port and a single-word read port. A fetch engine streams a zero-padded TILE_DIM x TILE_DIM matrix tile, or a single vector, out one row per cycle with a valid/ready handshake, instead of a one-shot full-tile read. It sits between the host loader and the systolic array/vector unit. It adds a caller-supplied row stride, padding rules, error reporting and backpressure.

---
 rtl/tpu_mem_pkg.sv | 17 +
 rtl/tile_row_gather.sv | 40 ++++
 rtl/tile_fetch_memory.sv | 183 ++++++++++++++++++
 tb/tb_tile_fetch_memory.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_mem_pkg.sv
// Shared types and default sizing for the TTPU tile scratchpad.
package tpu_mem_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 20;
  localparam int DEF_TILE_DIM = 32;
  localparam int DEF_DIM_W    = 6;

  typedef logic [DEF_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/tile_row_gather.sv
// Combinational gather of one zero-padded tile row from the scratchpad array,
// row-major or column-major (transpose) depending on the transpose input.
module tile_row_gather
  import tpu_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int TILE_DIM = DEF_TILE_DIM,
  parameter int DIM_W    = DEF_DIM_W
) (
  input  logic [DATA_W-1:0]          mem [2**ADDR_W],
  input  logic [ADDR_W-1:0]          base,
  input  logic [ADDR_W-1:0]          stride,
  input  logic [DIM_W-1:0]           row_sel,
  input  logic [DIM_W-1:0]           m,
  input  logic [DIM_W-1:0]           n,
  input  logic                       transpose,
  output logic [TILE_DIM*DATA_W-1:0] row
);

  logic [ADDR_W-1:0] row_off;

  assign row_off = ADDR_W'(row_sel);

  // Transposed rows walk down a source column: row r is column r, word j is
  // source row j, so the roles of the row and column bounds swap.
  always_comb begin
    row = '0;
    for (int j = 0; j < TILE_DIM; j++) begin
      if (transpose) begin
        if ((row_sel < n) && (j < int'(m)))
          row[j*DATA_W +: DATA_W] = mem[base + ADDR_W'(j) * stride + row_off];
      end else begin
        if ((row_sel < m) && (j < int'(n)))
          row[j*DATA_W +: DATA_W] = mem[base + row_off * stride + ADDR_W'(j)];
      end
    end
  end

endmodule

// File: rtl/tile_fetch_memory.sv
// Word-addressed scratchpad with a streaming tile/vector fetch engine.
// Column-major gather is built only when TTPU_TRANSPOSE_EN is defined.
module tile_fetch_memory
  import tpu_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int TILE_DIM = DEF_TILE_DIM,
  parameter int DIM_W    = DEF_DIM_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       start,
  input  logic                       vec_mode,
  input  logic                       transpose,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [DIM_W-1:0]           rows,
  input  logic [DIM_W-1:0]           cols,
  input  logic [ADDR_W-1:0]          stride,
  output logic                       busy,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [TILE_DIM*DATA_W-1:0] row_data,
  output logic [DIM_W-1:0]           row_idx,
  output logic                       row_last,
  output logic                       done,
  output logic                       err
);

`ifdef TTPU_TRANSPOSE_EN
  localparam logic XPOSE_EN = 1'b1;
`else
  localparam logic XPOSE_EN = 1'b0;
`endif

  localparam logic [DIM_W-1:0] TILE_LIMIT = DIM_W'(TILE_DIM);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  fetch_state_e state, next_state;
  logic accept, reject, advance, bad_req;

  logic              vec_q, trans_q;
  logic [ADDR_W-1:0] base_q, stride_q;
  logic [DIM_W-1:0]  rows_q, cols_q;

  logic [ADDR_W-1:0]          g_base, g_stride;
  logic [DIM_W-1:0]           g_row, g_m, g_n;
  logic                       g_trans;
  logic [TILE_DIM*DATA_W-1:0] gather_row;
  logic [DIM_W-1:0]           next_idx, last_idx;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  assign bad_req = (cols == '0) || (cols > TILE_LIMIT) ||
                   (!vec_mode && ((rows == '0) || (rows > TILE_LIMIT)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_req) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = STREAM;
          end
        end
      end
      STREAM: begin
        if (row_ready) begin
          if (row_last) next_state = DONE;
          else          advance    = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state == STREAM);
  assign row_valid = (state == STREAM);
  assign done      = (state == DONE);

  assign next_idx = row_idx + DIM_W'(1);
  assign last_idx = vec_q ? '0 : DIM_W'(TILE_DIM - 1);

  // Row 0 is gathered straight from the request inputs so it can be loaded on
  // the accepting edge; later rows use the latched request.
  always_comb begin
    g_base   = base_q;
    g_stride = stride_q;
    g_row    = next_idx;
    g_m      = vec_q ? DIM_W'(1) : rows_q;
    g_n      = cols_q;
    g_trans  = trans_q;
    if (state == IDLE) begin
      g_base   = base_addr;
      g_stride = stride;
      g_row    = '0;
      g_m      = vec_mode ? DIM_W'(1) : rows;
      g_n      = cols;
      g_trans  = XPOSE_EN & ~vec_mode & transpose;
    end
  end

  tile_row_gather #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .TILE_DIM (TILE_DIM),
    .DIM_W    (DIM_W)
  ) u_gather (
    .mem       (mem),
    .base      (g_base),
    .stride    (g_stride),
    .row_sel   (g_row),
    .m         (g_m),
    .n         (g_n),
    .transpose (g_trans),
    .row       (gather_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      row_data <= '0;
      row_idx  <= '0;
      row_last <= 1'b0;
      vec_q    <= 1'b0;
      trans_q  <= 1'b0;
      base_q   <= '0;
      stride_q <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
    end else begin
      err <= reject;
      if (accept) begin
        vec_q    <= vec_mode;
        trans_q  <= XPOSE_EN & ~vec_mode & transpose;
        base_q   <= base_addr;
        stride_q <= stride;
        rows_q   <= rows;
        cols_q   <= cols;
        row_data <= gather_row;
        row_idx  <= '0;
        row_last <= vec_mode || (TILE_DIM == 1);
      end else if (advance) begin
        row_data <= gather_row;
        row_idx  <= next_idx;
        row_last <= (next_idx == last_idx);
      end
    end
  end

endmodule

// File: tb/tb_tile_fetch_memory.sv
// Directed self-checking bench for tile_fetch_memory (default parameters).
module tb_tile_fetch_memory;
  import tpu_mem_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 20;
  localparam int TD   = 32;
  localparam int DIMW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              start = 1'b0;
  logic              vec_mode = 1'b0;
  logic              transpose = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [DIMW-1:0]   rows = '0;
  logic [DIMW-1:0]   cols = '0;
  logic [AW-1:0]     stride = '0;
  logic              busy;
  logic              row_valid;
  logic              row_ready = 1'b1;
  logic [TD*DW-1:0]  row_data;
  logic [DIMW-1:0]   row_idx;
  logic              row_last;
  logic              done;
  logic              err;

  int tests_run    = 0;
  int tests_failed = 0;

  tile_fetch_memory dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .start(start), .vec_mode(vec_mode), .transpose(transpose),
    .base_addr(base_addr), .rows(rows), .cols(cols), .stride(stride),
    .busy(busy), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_idx(row_idx), .row_last(row_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic vm, input logic tr, input logic [AW-1:0] b,
                        input logic [DIMW-1:0] m, input logic [DIMW-1:0] n,
                        input logic [AW-1:0] s);
    vec_mode = vm; transpose = tr; base_addr = b; rows = m; cols = n; stride = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Matrix tile base=100, stride=32 over mem[100+i]=i: word j of row k is k*32+j.
  function automatic logic [TD*DW-1:0] mat_row(input int r, input int m, input int n);
    logic [TD*DW-1:0] v;
    v = '0;
    for (int j = 0; j < TD; j++)
      if (r < m && j < n) v[j*DW +: DW] = 16'(r*32 + j);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if ({rd_data, rd_valid, busy, row_valid, row_idx, row_last, done, err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got rd_data=%h rd_valid=%b busy=%b row_valid=%b row_idx=%0d row_last=%b done=%b err=%b, want all 0",
               rd_data, rd_valid, busy, row_valid, row_idx, row_last, done, err);
    end
    tests_run++;
    if (row_data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_row_data: got %h want 0", row_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_matrix();
    logic [TD*DW-1:0] exp;
    wr_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      wr_addr = AW'(100 + i); wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b0;
    row_ready = 1'b1;
    launch(1'b0, 1'b0, 20'd100, 6'd3, 6'd4, 20'd32);
    for (int r = 0; r < TD; r++) begin
      exp = mat_row(r, 3, 4);
      tests_run++;
      if (row_data !== exp) begin
        tests_failed++;
        $display("[TB] FAIL matrix_row%0d: got %h want %h", r, row_data, exp);
      end
      tests_run++;
      if (row_valid !== 1'b1 || busy !== 1'b1 || row_idx !== DIMW'(r) || row_last !== (r == TD-1)) begin
        tests_failed++;
        $display("[TB] FAIL matrix_ctrl%0d: got valid=%b busy=%b idx=%0d last=%b want 1 1 %0d %b",
                 r, row_valid, busy, row_idx, row_last, r, (r == TD-1));
      end
      tick();
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || row_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL matrix_done: got done=%b busy=%b valid=%b want 1 0 0", done, busy, row_valid);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL matrix_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_vector();
    logic [TD*DW-1:0] exp;
    for (int i = 0; i < 7; i++) write_word(AW'(5 + i), 16'h0500 + 16'(i));
    exp = '0;
    for (int j = 0; j < 7; j++) exp[j*DW +: DW] = 16'h0500 + 16'(j);
    row_ready = 1'b1;
    launch(1'b1, 1'b0, 20'd5, 6'd0, 6'd7, 20'd0);
    tests_run++;
    if (row_data !== exp || row_valid !== 1'b1 || row_last !== 1'b1 || row_idx !== '0) begin
      tests_failed++;
      $display("[TB] FAIL vector_row: got data=%h valid=%b last=%b idx=%0d want data=%h 1 1 0",
               row_data, row_valid, row_last, row_idx, exp);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL vector_done: got done=%b busy=%b want 1 0", done, busy);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [TD*DW-1:0] exp;
    int expect_idx = 0;
    int handshakes = 0;
    int cycle = 0;
    bit finished = 1'b0;
    bit pat;
    row_ready = 1'b1;
    launch(1'b0, 1'b0, 20'd100, 6'd3, 6'd4, 20'd32);
    while (!finished && cycle < 300) begin
      if (done) begin
        finished = 1'b1;
      end else begin
        if (row_valid) begin
          exp = mat_row(expect_idx, 3, 4);
          tests_run++;
          if (row_idx !== DIMW'(expect_idx) || row_data !== exp) begin
            tests_failed++;
            $display("[TB] FAIL bp_row c%0d: got idx=%0d data=%h want idx=%0d data=%h",
                     cycle, row_idx, row_data, expect_idx, exp);
          end
        end
        pat = (cycle % 4 == 0) || (cycle % 4 == 3);
        row_ready = pat;
        if (row_valid && pat) begin
          handshakes++;
          expect_idx++;
        end
        tick();
        cycle++;
      end
    end
    tests_run++;
    if (!finished || handshakes != TD) begin
      tests_failed++;
      $display("[TB] FAIL bp_count: got handshakes=%0d finished=%b want %0d 1", handshakes, finished, TD);
    end
    row_ready = 1'b1;
    tick();
  endtask

  task automatic test_boundary();
    logic [TD*DW-1:0] exp;
    write_word(20'hFFFFE, 16'hA001);
    write_word(20'hFFFFF, 16'hA002);
    write_word(20'h00000, 16'hA003);
    write_word(20'h00001, 16'hA004);
    exp = '0;
    exp[0*DW +: DW] = 16'hA001;
    exp[1*DW +: DW] = 16'hA002;
    exp[2*DW +: DW] = 16'hA003;
    exp[3*DW +: DW] = 16'hA004;
    row_ready = 1'b1;
    launch(1'b1, 1'b0, 20'hFFFFE, 6'd0, 6'd4, 20'd0);
    tests_run++;
    if (row_data !== exp) begin
      tests_failed++;
      $display("[TB] FAIL wrap_row: got %h want %h", row_data, exp);
    end
    tick(); tick();
  endtask

  task automatic test_reject();
    launch(1'b0, 1'b0, 20'd100, 6'd3, 6'd0, 20'd32);
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0 || row_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reject_cols0: got err=%b busy=%b valid=%b want 1 0 0", err, busy, row_valid);
    end
    tick();
    tests_run++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reject_pulse: got err=%b busy=%b want 0 0", err, busy);
    end
    launch(1'b0, 1'b0, 20'd100, 6'd33, 6'd4, 20'd32);
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reject_rows33: got err=%b busy=%b want 1 0", err, busy);
    end
    tick();
    launch(1'b1, 1'b0, 20'd5, 6'd0, 6'd33, 20'd0);
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reject_veclen33: got err=%b busy=%b want 1 0", err, busy);
    end
    tick();
  endtask

  task automatic test_transpose();
    logic [TD*DW-1:0] exp;
    row_ready = 1'b1;
    launch(1'b0, 1'b1, 20'd100, 6'd2, 6'd3, 20'd32);
    for (int r = 0; r < TD; r++) begin
      exp = '0;
`ifdef TTPU_TRANSPOSE_EN
      if (r < 3) begin
        exp[0*DW +: DW] = 16'(r);
        exp[1*DW +: DW] = 16'(32 + r);
      end
`else
      exp = mat_row(r, 2, 3);
`endif
      tests_run++;
      if (row_data !== exp || row_idx !== DIMW'(r)) begin
        tests_failed++;
        $display("[TB] FAIL transpose_row%0d: got idx=%0d data=%h want idx=%0d data=%h",
                 r, row_idx, row_data, r, exp);
      end
      tick();
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL transpose_done: got %b want 1", done);
    end
    transpose = 1'b0;
    tick();
  endtask

  task automatic test_collision_reset();
    // mem[200] currently holds 100 from the matrix fill.
    wr_en = 1'b1; wr_addr = 20'd200; wr_data = 16'hBEEF;
    rd_en = 1'b1; rd_addr = 20'd200;
    tick();
    wr_en = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd100) begin
      tests_failed++;
      $display("[TB] FAIL collision_old: got valid=%b data=%h want 1 0064", rd_valid, rd_data);
    end
    tick();
    rd_en = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
      tests_failed++;
      $display("[TB] FAIL read_new: got valid=%b data=%h want 1 beef", rd_valid, rd_data);
    end
    tick();
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rd_valid_drop: got %b want 0", rd_valid);
    end

    row_ready = 1'b1;
    launch(1'b0, 1'b0, 20'd100, 6'd3, 6'd4, 20'd32);
    for (int k = 0; k < 10; k++) tick();
    row_ready = 1'b0;
    tests_run++;
    if (row_idx !== 6'd10 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_row10: got idx=%0d busy=%b want 10 1", row_idx, busy);
    end
    launch(1'b0, 1'b0, 20'd0, 6'd3, 6'd0, 20'd0);
    tests_run++;
    if (err !== 1'b0 || row_idx !== 6'd10 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_while_busy: got err=%b idx=%0d busy=%b want 0 10 1", err, row_idx, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    row_ready = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || row_valid !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got busy=%b valid=%b done=%b want 0 0 0", busy, row_valid, done);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_done: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_matrix();
    test_vector();
    test_backpressure();
    test_boundary();
    test_reject();
    test_transpose();
    test_collision_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
